// File: rtl/de_pipe_reg.sv
// de_pipe_reg: Decode->Execute pipeline register with stall/bubble, perf counters, deadlock watchdog
// Ports: clk_i/rst_i (sync, active-high); D_stall_i/D_bubble_i hazard controls;
//        D_* decoded fields in; E_* registered fields out; stall/bubble/issue counters; deadlock_o sticky
module de_pipe_reg #(
    parameter int OP_W      = 8,
    parameter int XLEN      = 32,
    parameter int CNT_W     = 32,
    parameter int STALL_MAX = 15
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             D_stall_i,
    input  logic             D_bubble_i,
    input  logic             D_valid_i,
    input  logic [XLEN-1:0]  D_pc_i,
    input  logic [XLEN-1:0]  D_instr_i,
    input  logic [OP_W-1:0]  D_epcode_i,
    input  logic [4:0]       D_rs1_i,
    input  logic [4:0]       D_rs2_i,
    input  logic [4:0]       D_dstE_i,
    input  logic             D_need_dstE_i,
    input  logic [XLEN-1:0]  D_imm_i,
    output logic             E_valid_o,
    output logic [XLEN-1:0]  E_pc_o,
    output logic [XLEN-1:0]  E_instr_o,
    output logic [XLEN-1:0]  E_imm_o,
    output logic [OP_W-1:0]  E_epcode_o,
    output logic [4:0]       E_rs1_o,
    output logic [4:0]       E_rs2_o,
    output logic [4:0]       E_dstE_o,
    output logic             E_need_dstE_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] bubble_cnt_o,
    output logic [CNT_W-1:0] issue_cnt_o,
    output logic             deadlock_o
);
    logic             w_stall_only, w_issue;
    logic [7:0]       w_run_nxt;
    logic             r_valid, r_need, r_dl;
    logic [XLEN-1:0]  r_pc, r_instr, r_imm;
    logic [OP_W-1:0]  r_op;
    logic [4:0]       r_rs1, r_rs2, r_dst;
    logic [CNT_W-1:0] r_stall_cnt, r_bubble_cnt, r_issue_cnt;
    logic [7:0]       r_run;
    // a bubble overrides a simultaneous stall, so a stall only counts when no bubble is present
    assign w_stall_only = D_stall_i && !D_bubble_i;
    assign w_issue      = !D_stall_i && !D_bubble_i && D_valid_i;
    assign w_run_nxt    = r_run + {7'd0, ~&r_run};
    // bubble clears opcode and need_dstE so the hazard unit never sees a phantom load-use
    always_ff @(posedge clk_i) begin
        if (rst_i || D_bubble_i) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_instr <= '0;
            r_imm   <= '0;
            r_op    <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_dst   <= '0;
            r_need  <= 1'b0;
        end else if (!D_stall_i) begin
            r_valid <= D_valid_i;
            r_pc    <= D_pc_i;
            r_instr <= D_instr_i;
            r_imm   <= D_imm_i;
            r_op    <= D_valid_i ? D_epcode_i : '0;
            r_rs1   <= D_rs1_i;
            r_rs2   <= D_rs2_i;
            r_dst   <= D_dstE_i;
            r_need  <= D_valid_i && D_need_dstE_i;
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
            r_issue_cnt  <= '0;
            r_run        <= '0;
            r_dl         <= 1'b0;
        end else begin
            if (w_stall_only) r_stall_cnt <= r_stall_cnt + CNT_W'(~&r_stall_cnt);
            if (D_bubble_i) r_bubble_cnt <= r_bubble_cnt + CNT_W'(~&r_bubble_cnt);
            if (w_issue) r_issue_cnt <= r_issue_cnt + CNT_W'(~&r_issue_cnt);
            r_run <= w_stall_only ? w_run_nxt : 8'd0;
            if (w_stall_only && w_run_nxt >= 8'(STALL_MAX)) r_dl <= 1'b1;
        end
    end
    assign E_valid_o     = r_valid;
    assign E_pc_o        = r_pc;
    assign E_instr_o     = r_instr;
    assign E_imm_o       = r_imm;
    assign E_epcode_o    = r_op;
    assign E_rs1_o       = r_rs1;
    assign E_rs2_o       = r_rs2;
    assign E_dstE_o      = r_dst;
    assign E_need_dstE_o = r_need;
    assign stall_cnt_o   = r_stall_cnt;
    assign bubble_cnt_o  = r_bubble_cnt;
    assign issue_cnt_o   = r_issue_cnt;
    assign deadlock_o    = r_dl;
endmodule

// File: tb/tb_de_pipe_reg.sv
// tb_de_pipe_reg: directed + random checks of de_pipe_reg against a behavioural model
module tb_de_pipe_reg;
    localparam int OPW  = 8;
    localparam int CW   = 3;
    localparam int SMAX = 4;
    localparam int MAXC = (1 << CW) - 1;
    logic clk = 1'b0, rst = 1'b0;
    logic d_stall = 0, d_bubble = 0, d_valid = 0, d_need = 0;
    logic [31:0] d_pc = 0, d_instr = 0, d_imm = 0;
    logic [OPW-1:0] d_op = 0;
    logic [4:0] d_rs1 = 0, d_rs2 = 0, d_dst = 0;
    logic e_valid, e_need, dl;
    logic [31:0] e_pc, e_instr, e_imm;
    logic [OPW-1:0] e_op;
    logic [4:0] e_rs1, e_rs2, e_dst;
    logic [CW-1:0] stl_cnt, bub_cnt, iss_cnt;
    int errors = 0, checks = 0;
    logic m_valid, m_need, m_dl;
    logic [31:0] m_pc, m_instr, m_imm;
    logic [OPW-1:0] m_op;
    logic [4:0] m_rs1, m_rs2, m_dst;
    int m_stl, m_bub, m_iss, m_run;

    de_pipe_reg #(.OP_W(OPW), .XLEN(32), .CNT_W(CW), .STALL_MAX(SMAX)) dut (
        .clk_i(clk), .rst_i(rst), .D_stall_i(d_stall), .D_bubble_i(d_bubble),
        .D_valid_i(d_valid), .D_pc_i(d_pc), .D_instr_i(d_instr), .D_epcode_i(d_op),
        .D_rs1_i(d_rs1), .D_rs2_i(d_rs2), .D_dstE_i(d_dst), .D_need_dstE_i(d_need),
        .D_imm_i(d_imm), .E_valid_o(e_valid), .E_pc_o(e_pc), .E_instr_o(e_instr),
        .E_imm_o(e_imm), .E_epcode_o(e_op), .E_rs1_o(e_rs1), .E_rs2_o(e_rs2),
        .E_dstE_o(e_dst), .E_need_dstE_o(e_need), .stall_cnt_o(stl_cnt),
        .bubble_cnt_o(bub_cnt), .issue_cnt_o(iss_cnt), .deadlock_o(dl)
    );

    always #5 clk = ~clk;

    function automatic int sat(input int v);
        return (v < MAXC) ? v + 1 : MAXC;
    endfunction

    task automatic clear_fields();
        {m_valid, m_need} = '0;
        {m_pc, m_instr, m_imm, m_op, m_rs1, m_rs2, m_dst} = '0;
    endtask

    task automatic model_edge();
        if (rst) begin
            clear_fields();
            {m_stl, m_bub, m_iss, m_run} = '0;
            m_dl = 1'b0;
        end else if (d_bubble) begin
            clear_fields();
            m_bub = sat(m_bub);
            m_run = 0;
        end else if (d_stall) begin
            m_stl = sat(m_stl);
            m_run = (m_run < 255) ? m_run + 1 : 255;
            if (m_run >= SMAX) m_dl = 1'b1;
        end else begin
            m_valid = d_valid;
            m_pc = d_pc; m_instr = d_instr; m_imm = d_imm;
            m_rs1 = d_rs1; m_rs2 = d_rs2; m_dst = d_dst;
            m_op = d_valid ? d_op : '0;
            m_need = d_valid & d_need;
            if (d_valid) m_iss = sat(m_iss);
            m_run = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("E_valid", 32'(e_valid), 32'(m_valid));
        chk("E_pc", e_pc, m_pc);
        chk("E_instr", e_instr, m_instr);
        chk("E_imm", e_imm, m_imm);
        chk("E_epcode", 32'(e_op), 32'(m_op));
        chk("E_rs1", 32'(e_rs1), 32'(m_rs1));
        chk("E_rs2", 32'(e_rs2), 32'(m_rs2));
        chk("E_dstE", 32'(e_dst), 32'(m_dst));
        chk("E_need_dstE", 32'(e_need), 32'(m_need));
        chk("stall_cnt", 32'(stl_cnt), 32'(m_stl));
        chk("bubble_cnt", 32'(bub_cnt), 32'(m_bub));
        chk("issue_cnt", 32'(iss_cnt), 32'(m_iss));
        chk("deadlock", 32'(dl), 32'(m_dl));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic rnd_d();
        d_valid = 1'($urandom);
        d_need  = 1'($urandom);
        d_pc    = $urandom;
        d_instr = $urandom;
        d_imm   = $urandom;
        d_op    = OPW'(1 << $urandom_range(0, OPW - 1));
        d_rs1   = 5'($urandom);
        d_rs2   = 5'($urandom);
        d_dst   = 5'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rnd_d();
        d_valid = 1'b1;
        d_need = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        {m_stl, m_bub, m_iss, m_run} = '0;
        m_dl = 1'b0;
        clear_fields();
        #2;
        do_reset();
        chk("reset_valid_const", 32'(e_valid), 32'd0);
        chk("reset_issue_const", 32'(iss_cnt), 32'd0);
        // basic load
        rnd_d();
        d_valid = 1; d_pc = 32'h100; d_dst = 5'd5; d_need = 1;
        cyc();
        chk("load_pc_const", e_pc, 32'h100);
        chk("load_dst_const", 32'(e_dst), 32'd5);
        chk("load_need_const", 32'(e_need), 32'd1);
        chk("load_issue_const", 32'(iss_cnt), 32'd1);
        // stall three cycles while decode keeps changing
        d_stall = 1;
        for (int i = 0; i < 3; i++) begin
            rnd_d();
            cyc();
        end
        chk("stall_pc_frozen", e_pc, 32'h100);
        chk("stall_cnt_const", 32'(stl_cnt), 32'd3);
        // bubble and stall together with a load-class opcode waiting in decode
        d_bubble = 1; d_valid = 1; d_need = 1; d_op = 8'h02;
        cyc();
        chk("bub_valid_const", 32'(e_valid), 32'd0);
        chk("bub_op_const", 32'(e_op), 32'd0);
        chk("bub_need_const", 32'(e_need), 32'd0);
        chk("bub_cnt_const", 32'(bub_cnt), 32'd1);
        chk("bub_stall_unchanged", 32'(stl_cnt), 32'd3);
        d_bubble = 0; d_stall = 0;
        // invalid load: fields copied but opcode and need forced low
        rnd_d();
        d_valid = 0; d_need = 1; d_op = 8'h10;
        cyc();
        chk("inv_op_const", 32'(e_op), 32'd0);
        chk("inv_need_const", 32'(e_need), 32'd0);
        // watchdog: one short of the limit, release, then a full run
        do_reset();
        d_stall = 1;
        for (int i = 0; i < 3; i++) cyc();
        chk("wd_no_trip_short", 32'(dl), 32'd0);
        d_stall = 0;
        rnd_d();
        cyc();
        chk("wd_no_trip_release", 32'(dl), 32'd0);
        d_stall = 1;
        for (int i = 0; i < 3; i++) cyc();
        chk("wd_before_4th", 32'(dl), 32'd0);
        cyc();
        chk("wd_trip_4th", 32'(dl), 32'd1);
        d_stall = 0;
        cyc();
        cyc();
        chk("wd_sticky", 32'(dl), 32'd1);
        do_reset();
        chk("wd_cleared", 32'(dl), 32'd0);
        // issue counter saturation
        for (int i = 0; i < 10; i++) begin
            rnd_d();
            d_valid = 1;
            cyc();
        end
        chk("issue_sat_const", 32'(iss_cnt), 32'(MAXC));
        // reset in the middle of a stall run
        d_stall = 1;
        cyc();
        cyc();
        do_reset();
        d_stall = 0;
        // random traffic
        for (int i = 0; i < 400; i++) begin
            rnd_d();
            rst      = ($urandom_range(0, 49) == 0);
            d_stall  = ($urandom_range(0, 99) < 45);
            d_bubble = ($urandom_range(0, 99) < 12);
            cyc();
        end
        rst = 0; d_stall = 0; d_bubble = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
